// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: constants shared by the LoongArch pipeline stages.
//   RESET_PC_DEF    : default address of the first fetch after reset
//   NOP_INST        : canonical NOP (andi r0,r0,0)
//   FS_TO_DS_BUS_WD : width of {fs_pc, fs_inst}
//   BR_BUS_WD       : width of {br_taken, br_target}
//   pc_misaligned() : true when a PC is not word aligned
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF    = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST        = 32'h0340_0000;
  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if: signals between the fetch stage, the decode stage (ID) and the
// synchronous instruction SRAM.
//   ID -> IF   : ds_allowin, br_taken, br_target
//   IF -> ID   : fs_to_ds_valid, fs_pc, fs_inst (+ fs_excp_adef when
//                IF_ADEF_EN is defined)
//   IF <-> SRAM: inst_sram_en/we/addr/wdata out, inst_sram_rdata in
// modport master is the fetch stage; modport slave is its environment.
// ---------------------------------------------------------------------------
interface if_stage_if;

  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
`ifdef IF_ADEF_EN
  logic        fs_excp_adef;
`endif
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_taken, br_target, inst_sram_rdata,
    output fs_to_ds_valid, fs_pc, fs_inst,
`ifdef IF_ADEF_EN
    output fs_excp_adef,
`endif
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_taken, br_target, inst_sram_rdata,
    input  fs_to_ds_valid, fs_pc, fs_inst,
`ifdef IF_ADEF_EN
    input  fs_excp_adef,
`endif
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_inst_buf.sv
// ---------------------------------------------------------------------------
// if_inst_buf: holds the SRAM word of a stalled fetch slot.
// The SRAM only presents read data for one cycle after a request, so when ID
// stalls the word is captured here and offered from the buffer afterwards.
//   clk, reset  : clock, asynchronous active-high reset
//   capture     : slot is valid, ID is stalling and no redirect is pending
//   slot_advance: fetch stage accepts a new slot (handoff or redirect)
//   force_nop   : current slot is a faulting fetch; offer a NOP
//   sram_rdata  : raw SRAM read data
//   fs_inst     : instruction offered to ID
// ---------------------------------------------------------------------------
module if_inst_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        slot_advance,
  input  logic        force_nop,
  input  logic [31:0] sram_rdata,
  output logic [31:0] fs_inst
);

  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  // Capture only on the first stall cycle; later cycles may see stale SRAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_buf       <= 32'h0;
      inst_buf_valid <= 1'b0;
    end else if (slot_advance) begin
      inst_buf_valid <= 1'b0;
    end else if (capture && !inst_buf_valid) begin
      inst_buf       <= sram_rdata;
      inst_buf_valid <= 1'b1;
    end
  end

  always_comb begin
    fs_inst = inst_buf_valid ? inst_buf : sram_rdata;
    if (force_nop) fs_inst = NOP_INST;
  end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the pipelined LoongArch core.
// Generates nextpc, drives the 1-cycle-latency instruction SRAM, holds one
// fetched instruction for ID under valid/allowin and squashes the wrong-path
// slot when ID redirects.
//   RESET_PC : address of the first fetch after reset
//   clk      : core clock
//   reset    : asynchronous active-high reset
//   fs_bus   : if_stage_if.master (ID handshake, redirect, SRAM port)
// Optional: define IF_ADEF_EN to flag misaligned fetch PCs on fs_excp_adef,
// suppress the SRAM request for them and offer a NOP in that slot.
// ---------------------------------------------------------------------------
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.master fs_bus
);

  logic        fs_valid;
  logic [31:0] fs_pc_r;
  logic [31:0] nextpc;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_ok;
  logic        slot_adef;
  logic        stall_capture;

  assign to_fs_valid = ~reset;
  assign fs_ready_go = 1'b1;
  // A redirect always frees the slot: its contents are wrong-path.
  assign fs_allowin  = ~fs_valid | (fs_ready_go & fs_bus.ds_allowin) | fs_bus.br_taken;
  assign nextpc      = fs_bus.br_taken ? fs_bus.br_target : fs_pc_r + 32'd4;

`ifdef IF_ADEF_EN
  assign fetch_ok            = ~pc_misaligned(nextpc);
  assign slot_adef           = pc_misaligned(fs_pc_r);
  assign fs_bus.fs_excp_adef = fs_valid & slot_adef;
`else
  assign fetch_ok  = 1'b1;
  assign slot_adef = 1'b0;
`endif

  assign fs_bus.inst_sram_en    = to_fs_valid & fs_allowin & fetch_ok;
  assign fs_bus.inst_sram_we    = 1'b0;
  assign fs_bus.inst_sram_addr  = nextpc;
  assign fs_bus.inst_sram_wdata = 32'h0;

  // Reset to RESET_PC-4 so the first sequential nextpc is RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc_r  <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      fs_pc_r  <= nextpc;
    end
  end

  assign stall_capture = fs_valid & ~fs_bus.ds_allowin & ~fs_bus.br_taken;

  if_inst_buf u_inst_buf (
    .clk          (clk),
    .reset        (reset),
    .capture      (stall_capture),
    .slot_advance (fs_allowin),
    .force_nop    (slot_adef),
    .sram_rdata   (fs_bus.inst_sram_rdata),
    .fs_inst      (fs_bus.fs_inst)
  );

  assign fs_bus.fs_to_ds_valid = fs_valid & ~fs_bus.br_taken;
  assign fs_bus.fs_pc          = fs_pc_r;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: directed bench for if_stage. A behavioural SRAM returns a
// fixed word per address one cycle after an enabled request and random data
// otherwise. Inputs change on the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .fs_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1c00_0008) ? 32'h0280_0421 : ~a;
  endfunction

  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'h0;

    // Test 1: reset, then sequential fetch
    #1;
    check("rst_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("rst_en", 32'(bus.inst_sram_en), 32'd0);
    check("rst_pc", bus.fs_pc, 32'h1bff_fffc);
    check("we_tied", 32'(bus.inst_sram_we), 32'd0);
    check("wdata_tied", bus.inst_sram_wdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("c0_en", 32'(bus.inst_sram_en), 32'd1);
    check("c0_addr", bus.inst_sram_addr, 32'h1c00_0000);
    check("c0_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    @(negedge clk); #1;
    check("c1_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("c1_pc", bus.fs_pc, 32'h1c00_0000);
    check("c1_inst", bus.fs_inst, 32'he3ff_ffff);
    check("c1_addr", bus.inst_sram_addr, 32'h1c00_0004);
    @(negedge clk); #1;
    check("c2_pc", bus.fs_pc, 32'h1c00_0004);
    check("c2_addr", bus.inst_sram_addr, 32'h1c00_0008);

    // Test 2: 4-cycle stall holding 1c000008
    @(negedge clk);
    bus.ds_allowin = 1'b0;
    #1;
    check("s0_pc", bus.fs_pc, 32'h1c00_0008);
    check("s0_inst", bus.fs_inst, 32'h0280_0421);
    check("s0_en", 32'(bus.inst_sram_en), 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      check("stall_inst", bus.fs_inst, 32'h0280_0421);
      check("stall_en", 32'(bus.inst_sram_en), 32'd0);
      check("stall_pc", bus.fs_pc, 32'h1c00_0008);
      check("stall_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    end
    @(negedge clk);
    bus.ds_allowin = 1'b1;
    #1;
    check("rel_en", 32'(bus.inst_sram_en), 32'd1);
    check("rel_addr", bus.inst_sram_addr, 32'h1c00_000c);
    check("rel_inst", bus.fs_inst, 32'h0280_0421);
    @(negedge clk);
    // Branch back to 1c000008, squashing 1c00000c
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0008;
    #1;
    check("c8_pc", bus.fs_pc, 32'h1c00_000c);
    check("c8_inst", bus.fs_inst, 32'he3ff_fff3);
    check("c8_squash", 32'(bus.fs_to_ds_valid), 32'd0);

    // Test 3: redirect while holding 1c000008
    @(negedge clk);
    bus.br_target = 32'h1c00_0100;
    #1;
    check("br_pc", bus.fs_pc, 32'h1c00_0008);
    check("br_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("br_addr", bus.inst_sram_addr, 32'h1c00_0100);
    check("br_en", 32'(bus.inst_sram_en), 32'd1);
    @(negedge clk);
    bus.br_taken   = 1'b0;
    bus.ds_allowin = 1'b0;
    #1;
    check("tgt_pc", bus.fs_pc, 32'h1c00_0100);
    check("tgt_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("tgt_inst", bus.fs_inst, 32'he3ff_feff);

    // Test 4: redirect during a stall with the buffer loaded
    @(negedge clk); #1;
    check("bs_inst", bus.fs_inst, 32'he3ff_feff);
    check("bs_en", 32'(bus.inst_sram_en), 32'd0);
    @(negedge clk);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0040;
    #1;
    check("bsbr_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("bsbr_en", 32'(bus.inst_sram_en), 32'd1);
    check("bsbr_addr", bus.inst_sram_addr, 32'h1c00_0040);
    @(negedge clk);
    bus.br_taken   = 1'b0;
    bus.ds_allowin = 1'b1;
    #1;
    check("bsn_pc", bus.fs_pc, 32'h1c00_0040);
    check("bsn_inst", bus.fs_inst, 32'he3ff_ffbf);
    check("bsn_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("bsn_addr", bus.inst_sram_addr, 32'h1c00_0044);

    // Test 5: async reset mid-stream at 1c000020
    @(negedge clk);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0020;
    #1;
    check("r_addr", bus.inst_sram_addr, 32'h1c00_0020);
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    check("r_pc", bus.fs_pc, 32'h1c00_0020);
    check("r_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("ar_en", 32'(bus.inst_sram_en), 32'd0);
    check("ar_pc", bus.fs_pc, 32'h1bff_fffc);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rr_en", 32'(bus.inst_sram_en), 32'd1);
    check("rr_addr", bus.inst_sram_addr, 32'h1c00_0000);
    check("rr_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    @(negedge clk);
    // Wrap check: redirect to ffff_fffc
    bus.br_taken  = 1'b1;
    bus.br_target = 32'hffff_fffc;
    #1;
    check("rr1_pc", bus.fs_pc, 32'h1c00_0000);
    check("rr1_inst", bus.fs_inst, 32'he3ff_ffff);
    check("w_addr", bus.inst_sram_addr, 32'hffff_fffc);
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    check("w_pc", bus.fs_pc, 32'hffff_fffc);
    check("w_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("w_next", bus.inst_sram_addr, 32'h0000_0000);
    @(negedge clk); #1;
    check("w0_pc", bus.fs_pc, 32'h0000_0000);
    check("w0_inst", bus.fs_inst, 32'hffff_ffff);

`ifdef IF_ADEF_EN
    // Test 6: misaligned redirect target
    check("adef_clear", 32'(bus.fs_excp_adef), 32'd0);
    @(negedge clk);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0102;
    #1;
    check("adef_addr", bus.inst_sram_addr, 32'h1c00_0102);
    check("adef_en", 32'(bus.inst_sram_en), 32'd0);
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    check("adef_pc", bus.fs_pc, 32'h1c00_0102);
    check("adef_flag", 32'(bus.fs_excp_adef), 32'd1);
    check("adef_inst", bus.fs_inst, 32'h0340_0000);
    check("adef_valid", 32'(bus.fs_to_ds_valid), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the pipelined LoongArch core. It sits directly upstream of the decode stage (ID), replacing the single-cycle PC/fetch logic.
- It generates next-PC and drives the synchronous instruction SRAM, which has 1-cycle read latency.
- It holds one fetched instruction and hands it to ID under a valid/allowin handshake.
- It accepts branch redirects from ID and squashes the wrong-path instruction it currently holds.

Parameters:
RESET_PC, 32'h1c000000, address of the first instruction fetched after reset

Ports:
clk  in  1  core clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
ds_allowin  in  1  ID can accept an instruction this cycle
br_taken  in  1  redirect request from ID; asserted only in the cycle ID consumes a valid, ready branch
br_target  in  32  redirect target PC
fs_to_ds_valid  out  1  fs_pc/fs_inst hold a valid instruction for ID
fs_pc  out  32  PC of instruction offered to ID
fs_inst  out  32  instruction offered to ID
inst_sram_en  out  1  SRAM read enable
inst_sram_we  out  1  tied 0
inst_sram_addr  out  32  fetch address (= nextpc)
inst_sram_wdata  out  32  tied 0
inst_sram_rdata  in  32  SRAM data, valid the cycle after an enabled request

Behaviour:
- State: fs_valid, fs_pc_r, inst_buf[31:0], inst_buf_valid.
- Reset (async) values: fs_valid=0, fs_pc_r=RESET_PC-4, inst_buf_valid=0, inst_buf=0.
- Reset-derived outputs: fs_to_ds_valid=0 and inst_sram_en=0 while reset is high.
- nextpc = br_taken ? br_target : fs_pc_r+4. Addition is 32-bit; it wraps at 32'hffff_fffc -> 0.
- to_fs_valid = ~reset.
- fs_ready_go = 1.
- fs_allowin = ~fs_valid | ds_allowin | br_taken.
- inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc.
- On a clock edge with fs_allowin=1: fs_valid<=to_fs_valid, fs_pc_r<=nextpc.
- First fetch: it issues in the first cycle after reset deasserts, with addr=RESET_PC. fs_to_ds_valid rises one cycle later.
- fs_to_ds_valid = fs_valid & ~br_taken. The instruction held while br_taken=1 is the wrong-path sequential one: it is dropped and never reaches ID.
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata. fs_pc = fs_pc_r.
- Stall capture: if fs_valid & ~ds_allowin & ~br_taken & ~inst_buf_valid, then inst_buf<=inst_sram_rdata and inst_buf_valid<=1. SRAM output is not guaranteed stable after the first stall cycle.
- inst_buf_valid clears on any edge where fs_allowin=1, which covers both a handoff and a redirect.
- Redirect during stall: br_taken has priority. The buffered instruction is discarded and br_target is fetched in the same cycle.
- Latency: request in cycle N, instruction offered to ID in cycle N+1. Sustained throughput is 1 instruction/cycle with no bubbles.
- Exactly one bubble per taken branch (the squashed slot).
- Reset asserted mid-operation: all state clears immediately. Any in-flight SRAM data is ignored. Restart at RESET_PC.

Optional Feature:
IF_ADEF_EN:
- Defined:
  - Adds output fs_excp_adef (1 bit) = fs_valid & (fs_pc_r[1:0]!=0).
  - When nextpc[1:0]!=0 the stage still advances, but inst_sram_en=0.
  - fs_inst for that slot is forced to NOP 32'h0340_0000; fs_to_ds_valid follows the normal rules.
- Undefined:
  - Port is absent.
  - The low address bits pass to the SRAM unchecked.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC default
  - NOP encoding 32'h0340_0000
  - FS_TO_DS_BUS_WD=64 ({fs_pc, fs_inst})
  - BR_BUS_WD=33 ({br_taken, br_target})
- One natural sub-module: if_inst_buf. It contains the stall-capture register, its valid flag and the fs_inst mux.

Test Plan:
1. Reset high 3 cycles then release, ds_allowin=1:
   - inst_sram_addr sequence 1c000000, 1c000004, 1c000008.
   - fs_to_ds_valid first high one cycle after the first request, with fs_pc=1c000000.
2. Stall hold: ds_allowin=0 for 4 cycles while holding pc 1c000008 (rdata=0x02800421); SRAM rdata randomized after cycle 1:
   - fs_inst stays 0x02800421.
   - inst_sram_en=0 throughout.
   - On release, the next request is 1c00000c.
3. Redirect: br_taken=1 with br_target=1c000100 while fs holds 1c000008:
   - fs_to_ds_valid=0 that cycle; addr=1c000100.
   - Next cycle fs_pc=1c000100, valid=1.
   - 1c000008 is never accepted by ID.
4. Redirect during a 2-cycle stall with the buffer loaded:
   - The buffer is discarded.
   - The next fs_pc is br_target=1c000040 and fs_inst comes from SRAM, not the buffer.
5. Reset asserted async mid-stream at pc 1c000020:
   - fs_to_ds_valid drops without waiting for a clock edge.
   - After release, fetch restarts at 1c000000.
6. IF_ADEF_EN: br_target=1c000102:
   - inst_sram_en=0.
   - fs_excp_adef=1 with fs_inst=03400000.
   - Wrap check: pc ffff_fffc is followed by 0000_0000.
